// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port 32-bit data memory with byte/half/word access.
// Byte addressed and little-endian. The response comes one cycle after accept.
// At most one request is outstanding, and requests may run back-to-back.
// Handshakes: a request transfers on a posedge where req_valid & req_ready.
// A response transfers on a posedge where rsp_valid & rsp_ready.
// While rsp_valid is high, rsp_rdata/rsp_err hold until that transfer.
module dmem_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 7
) (
`ifdef USE_POWER_PINS
    inout  wire               vccd1,
    inout  wire               vssd1,
`endif
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // Storage is never reset; only accepted, error-free stores modify it.
    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              accept;
    logic              req_err;
    logic [31:0]       rd_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              wr_en;

    assign word_idx  = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign in_range  = (int'(word_idx) < DEPTH);
    assign rd_word   = in_range ? mem_q[mem_idx] : '0;

    assign req_ready = (state_q == IDLE) | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

    // Flag illegal sizes, misalignment and out-of-range word indices.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (!in_range) begin
            req_err = 1'b1;
        end
    end

    // Pick the addressed byte/half out of the current word and extend it.
    always_comb begin
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];
        load_val = '0;
        case (req_size)
            2'b00:   load_val = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~req_unsigned & half_sel[15]}}, half_sel};
            2'b10:   load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    // Lane enables and replicated write data for stores.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = req_wdata;
            end
        endcase
        wr_en = accept & req_we & ~req_err & ~reset;
    end

    // Next state and response capture; the response data is held until it is consumed.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            state_d = RESP;
            rdata_d = (req_err | req_we) ? 32'd0 : load_val;
            err_d   = req_err;
        end else if ((state_q == RESP) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Lane-masked memory write; a load on the next cycle sees the new data.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule
